// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, req/ready fetch FSM, redirects, decode field split.
// Build option: define IFETCH_MISALIGN_TRAP_EN to trap (HALT + sticky misalign) on unaligned redirect targets.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        fetch_timeout,
    output logic        misalign
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, VALID, HALT} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    // Handshake: a fetch completes in the cycle where imem_req & imem_ready are both high;
    // imem_req and imem_addr stay stable until then. instr_valid qualifies the instruction
    // for decode and it is consumed on the first rising edge where stall is low.
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign op        = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];

`ifndef IFETCH_MISALIGN_TRAP_EN
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr         <= NOP_INSTR;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b0;
            wait_cnt      <= '0;
            fetch_timeout <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                    state    <= REQ;
                end
                REQ: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= VALID;
                    end else if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
                        fetch_timeout <= 1'b1;
                        imem_req      <= 1'b0;
                        instr         <= NOP_INSTR;
                        state         <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                VALID: begin
                    // While stalled everything holds, including any redirect request.
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        if (redirect) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                            if (redirect_pc[1:0] != 2'b00) begin
                                misalign <= 1'b1;
                                state    <= HALT;
                            end else begin
                                pc       <= redirect_pc;
                                imem_req <= 1'b1;
                                state    <= REQ;
                            end
`else
                            pc       <= redirect_pc & 32'hFFFF_FFFC;
                            imem_req <= 1'b1;
                            state    <= REQ;
`endif
                        end else begin
                            pc       <= pc + 32'd4;
                            imem_req <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    instr       <= NOP_INSTR;
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboarded bench for ifetch_unit: random memory latency, random stall/redirect, directed corner cases.
// Honours IFETCH_MISALIGN_TRAP_EN the same way as the design.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        fetch_timeout;
    logic        misalign;

    ifetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .op(op), .funct3(funct3), .funct7(funct7),
        .fetch_timeout(fetch_timeout), .misalign(misalign)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard state: {pc, instr} of every instruction the memory has delivered
    logic [63:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc;

    // knobs steered by the main sequence
    bit          mem_en     = 1'b1;
    int          wait_lo    = 0;
    int          wait_hi    = 0;
    int          wait_left  = 0;
    int          stall_pct  = 100;
    int          redir_pct  = 0;
    bit          use_fixed  = 1'b0;
    logic [31:0] fixed_target = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(3, 0))
            0:       t = 32'hFFFF_FFF8;
            1:       t = 32'h0000_0102;
            default: t = $urandom();
        endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
        t = t & 32'hFFFF_FFFC;
`endif
        return t;
    endfunction

    // memory driver: answers each request after a chosen number of wait cycles
    initial begin
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_ready = 1'b0;
            if (mem_en && imem_req) begin
                check("imem_addr", imem_addr, model_pc);
                if (wait_left == 0) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    exp_q.push_back({model_pc, mem_word(model_pc)});
                    wait_left = $urandom_range(wait_hi, wait_lo);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // consumer driver + PC reference: a consumed instruction moves the PC to the
    // redirect target (word aligned) or to the next sequential word
    initial begin
        stall       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            stall       = ($urandom_range(99, 0) < stall_pct);
            redirect    = ($urandom_range(99, 0) < redir_pct);
            redirect_pc = use_fixed ? fixed_target : rand_target();
            if (!reset && instr_valid && !stall)
                model_pc = redirect ? (redirect_pc & 32'hFFFF_FFFC) : model_pc + 32'd4;
        end
    end

    // monitor: pops on each newly valid instruction, checks holding while stalled
    initial begin
        logic [63:0] cur;
        bit          have_cur;
        have_cur = 1'b0;
        cur      = 64'h0;
        forever begin
            @(negedge clk);
            if (instr_valid) begin
                check("no_req_while_valid", {31'b0, imem_req}, 32'h0);
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_instr", instr, 32'hxxxx_xxxx);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("instr", instr, cur[31:0]);
                        check("pc", pc, cur[63:32]);
                        check("pc_plus4", pc_plus4, cur[63:32] + 32'd4);
                        check("op", {25'b0, op}, {25'b0, cur[6:0]});
                        check("funct3", {29'b0, funct3}, {29'b0, cur[14:12]});
                        check("funct7", {25'b0, funct7}, {25'b0, cur[31:25]});
                    end
                end else begin
                    check("hold_instr", instr, cur[31:0]);
                    check("hold_pc", pc, cur[63:32]);
                end
            end else begin
                have_cur = 1'b0;
            end
        end
    end

    task automatic wait_sig(input int which, input bit lvl, input int bound, input string name);
        bit hit;
        bit v;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       v = instr_valid;
                1:       v = imem_req;
                2:       v = misalign;
                default: v = fetch_timeout;
            endcase
            hit = (v == lvl);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: got %0b expected %0b within %0d cycles", name, !lvl, lvl, bound);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        model_pc  = RESET_PC;
        wait_left = wait_lo;
        @(negedge clk);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_pc", pc, RESET_PC);
        check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        check("rst_fetch_timeout", {31'b0, fetch_timeout}, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        reset    = 1'b1;
        model_pc = RESET_PC;

        // first fetch with zero-wait memory: valid on the second cycle
        do_reset();
        cnt = 0;
        for (int i = 0; i < 20 && !instr_valid; i++) begin
            @(negedge clk);
            cnt++;
        end
        check("first_valid_latency", cnt, 2);
        check("first_op", {25'b0, op}, 32'h13);
        check("first_funct3", {29'b0, funct3}, 32'h0);
        check("first_pc", pc, 32'h0);
        check("first_pc_plus4", pc_plus4, 32'h4);

        // stalled with redirect pending: nothing moves, no new request
        redir_pct    = 100;
        use_fixed    = 1'b1;
        fixed_target = 32'h0000_0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_pc", pc, 32'h0);
            check("stall_instr", instr, 32'h0050_0093);
            check("stall_req", {31'b0, imem_req}, 32'h0);
        end
        stall_pct = 0;
        redir_pct = 0;
        wait_sig(1, 1'b1, 10, "req_after_stall");
        check("stall_release_addr", imem_addr, 32'h4);

        // redirect held high through REQ is ignored; taken once the instruction is valid
        redir_pct = 100;
        wait_sig(0, 1'b1, 10, "valid_at_4");
        check("pc_before_redirect", pc, 32'h4);
        wait_sig(1, 1'b1, 10, "req_after_redirect");
        check("redirect_addr", imem_addr, 32'h100);

        // unaligned redirect target
        stall_pct    = 100;
        fixed_target = 32'h0000_0102;
        wait_sig(0, 1'b1, 10, "valid_at_100");
        stall_pct = 0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        wait_sig(2, 1'b1, 10, "misalign");
        check("misalign_flag", {31'b0, misalign}, 32'h1);
        check("misalign_req", {31'b0, imem_req}, 32'h0);
        check("misalign_valid", {31'b0, instr_valid}, 32'h0);
        check("misalign_pc", pc, 32'h100);
        check("misalign_instr", instr, NOP_INSTR);
`else
        wait_sig(1, 1'b1, 10, "req_after_unaligned");
        check("aligned_redirect_addr", imem_addr, 32'h100);
        check("misalign_off", {31'b0, misalign}, 32'h0);
`endif
        redir_pct = 0;
        use_fixed = 1'b0;

        // three wait states: request held four cycles, sequential pcs
        wait_lo = 3;
        wait_hi = 3;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 50 && !instr_valid; i++) begin
            @(negedge clk);
            if (!instr_valid && imem_req) cnt++;
        end
        check("req_cycles_wait3", cnt, 4);
        check("seq_pc0", pc, 32'h0);
        for (int k = 1; k < 3; k++) begin
            wait_sig(0, 1'b0, 10, "valid_drop");
            wait_sig(0, 1'b1, 20, "valid_seq");
            check("seq_pc", pc, 32'(4 * k));
        end

        // memory never answers: timeout after WAIT_LIMIT cycles in REQ
        mem_en = 1'b0;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 100 && !fetch_timeout; i++) begin
            @(negedge clk);
            if (!fetch_timeout && imem_req) cnt++;
        end
        check("timeout_flag", {31'b0, fetch_timeout}, 32'h1);
        check("timeout_req_cycles", cnt, 16);
        stall_pct = 30;
        redir_pct = 50;
        repeat (5) @(negedge clk);
        check("halt_req", {31'b0, imem_req}, 32'h0);
        check("halt_valid", {31'b0, instr_valid}, 32'h0);
        check("halt_instr", instr, NOP_INSTR);
        check("halt_sticky", {31'b0, fetch_timeout}, 32'h1);
        mem_en = 1'b1;

        // random traffic against the reference model
        wait_lo   = 0;
        wait_hi   = 3;
        stall_pct = 30;
        redir_pct = 25;
        do_reset();
        repeat (400) @(negedge clk);
        mem_en    = 1'b0;
        stall_pct = 100;
        repeat (6) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        mem_en = 1'b1;
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
